// File: rtl/delay_chain_meter_pkg.sv
// Shared types for the delay-chain measurement blocks: FSM states and
// the error codes reported on err_o.
package delay_chain_meter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    MEASURE = 3'd2,
    RELAX   = 3'd3,
    FINISH  = 3'd4
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_RISE_TO = 2'b01;
  localparam logic [1:0] ERR_FALL_TO = 2'b10;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for bringing asynchronous levels into clk.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_reg;
  logic [W-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/delay_chain_meter.sv
// Launches an edge into the delay chain, times its arrival through a 2-flop
// synchronizer and accumulates 2^TRIALS_LOG2 trials into a sum and average.
module delay_chain_meter
  import delay_chain_meter_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int TRIALS_LOG2    = 2,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int SETTLE_CYCLES  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic                         abort_i,
  output logic                         launch_o,
  input  logic                         sense_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [1:0]                   err_o,
  output logic [CNT_W+TRIALS_LOG2-1:0] sum_o,
  output logic [CNT_W-1:0]             avg_o
);

  localparam int SUM_W   = CNT_W + TRIALS_LOG2;
  localparam int TRIAL_W = TRIALS_LOG2 + 1;

  localparam logic [TRIAL_W-1:0] LAST_TRIAL   = TRIAL_W'((1 << TRIALS_LOG2) - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX      = '1;
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);

  state_t               state_reg,   state_next;
  logic [CNT_W-1:0]     cnt_reg,     cnt_next;
  logic [CNT_W-1:0]     elapsed_reg, elapsed_next;
  logic [TRIAL_W-1:0]   trial_reg,   trial_next;
  logic [SUM_W-1:0]     acc_reg,     acc_next;
  logic [SUM_W-1:0]     sum_reg,     sum_next;
  logic [CNT_W-1:0]     avg_reg,     avg_next;
  logic [1:0]           err_reg,     err_next;
  logic                 done_reg,    done_next;
  logic                 launch_reg,  launch_next;
  logic                 sense_s;

  sync_2ff #(.W(1)) u_sense_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sense_i),
    .q     (sense_s)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    elapsed_next = elapsed_reg;
    trial_next   = trial_reg;
    acc_next     = acc_reg;
    sum_next     = sum_reg;
    avg_next     = avg_reg;
    err_next     = err_reg;
    done_next    = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (start_i) begin
          state_next   = SETTLE;
          cnt_next     = '0;
          elapsed_next = '0;
          trial_next   = '0;
          acc_next     = '0;
          err_next     = ERR_OK;
        end
      end

      SETTLE: begin
        // cnt tracks the current run of low samples, elapsed the total wait
        elapsed_next = sat_inc(elapsed_reg);
        if (sense_s) begin
          cnt_next = '0;
        end else if (cnt_reg == SETTLE_LAST) begin
          cnt_next   = '0;
          state_next = MEASURE;
        end else begin
          cnt_next = sat_inc(cnt_reg);
        end
        if (!(!sense_s && cnt_reg == SETTLE_LAST) && elapsed_reg == TIMEOUT_LAST) begin
          err_next   = ERR_FALL_TO;
          state_next = FINISH;
        end
      end

      MEASURE: begin
        // synchronizer latency stays in the count so a zero-delay chain reads 2
        if (sense_s) begin
          acc_next     = acc_reg + SUM_W'(cnt_reg);
          elapsed_next = '0;
          state_next   = RELAX;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          err_next   = ERR_RISE_TO;
          state_next = FINISH;
        end else begin
          cnt_next = sat_inc(cnt_reg);
        end
      end

      RELAX: begin
        elapsed_next = sat_inc(elapsed_reg);
        if (!sense_s) begin
          trial_next = trial_reg + TRIAL_W'(1);
          if (trial_reg == LAST_TRIAL) begin
            state_next = FINISH;
          end else begin
            state_next   = SETTLE;
            cnt_next     = '0;
            elapsed_next = '0;
          end
        end else if (elapsed_reg == TIMEOUT_LAST) begin
          err_next   = ERR_FALL_TO;
          state_next = FINISH;
        end
      end

      FINISH: begin
        sum_next   = acc_reg;
        avg_next   = CNT_W'(acc_reg >> TRIALS_LOG2);
        done_next  = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase

    // abort wins over any transition, leaving the reported results untouched
    if (abort_i && state_reg != IDLE) begin
      state_next = IDLE;
      err_next   = err_reg;
      sum_next   = sum_reg;
      avg_next   = avg_reg;
      done_next  = 1'b0;
    end

    launch_next = (state_next == MEASURE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      elapsed_reg <= '0;
      trial_reg   <= '0;
      acc_reg     <= '0;
      sum_reg     <= '0;
      avg_reg     <= '0;
      err_reg     <= ERR_OK;
      done_reg    <= 1'b0;
      launch_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      elapsed_reg <= elapsed_next;
      trial_reg   <= trial_next;
      acc_reg     <= acc_next;
      sum_reg     <= sum_next;
      avg_reg     <= avg_next;
      err_reg     <= err_next;
      done_reg    <= done_next;
      launch_reg  <= launch_next;
    end
  end

  assign launch_o = launch_reg;
  assign busy_o   = (state_reg != IDLE);
  assign done_o   = done_reg;
  assign err_o    = err_reg;
  assign sum_o    = sum_reg;
  assign avg_o    = avg_reg;

endmodule

// File: tb/tb_delay_chain_meter.sv
// Bench for delay_chain_meter: a chain model with configurable delay, a
// timeline model of each successful run and directed error/abort/reset cases.
module tb_delay_chain_meter;

  localparam int SETTLE = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        sense_i;
  logic        launch_o, busy_o, done_o;
  logic [1:0]  err_o;
  logic [17:0] sum_o;
  logic [15:0] avg_o;

  logic        start2 = 1'b0;
  logic        launch2, busy2, done2;
  logic [1:0]  err2;
  logic [17:0] sum2;
  logic [15:0] avg2;

  int tests = 0;
  int fails = 0;

  int          dly = 0;
  bit          tie1 = 1'b0;
  logic [15:0] sh = '0;

  always #5 clk = ~clk;

  // chain model: sense follows launch after dly whole cycles
  always @(posedge clk) sh <= {sh[14:0], launch_o};
  assign sense_i = tie1 ? 1'b1 : ((dly == 0) ? launch_o : sh[dly-1]);

  delay_chain_meter dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .launch_o(launch_o), .sense_i(sense_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .sum_o(sum_o), .avg_o(avg_o)
  );

  delay_chain_meter #(.TIMEOUT_CYCLES(50)) dut_to (
    .clk(clk), .rst_n(rst_n), .start_i(start2), .abort_i(1'b0),
    .launch_o(launch2), .sense_i(1'b0), .busy_o(busy2), .done_o(done2),
    .err_o(err2), .sum_o(sum2), .avg_o(avg2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Timeline model: each trial = SETTLE low cycles, a measure phase that
  // lasts until the synchronized edge arrives (count = d + 2), and a relax
  // phase of the same length while the falling edge travels back.
  function automatic int trial_count(input int d);
    return d + 2;
  endfunction
  function automatic int trial_period(input int d);
    return SETTLE + 2 * (trial_count(d) + 1);
  endfunction
  function automatic int run_len(input int d);
    return 4 * trial_period(d) + 1;
  endfunction

  int mdl_cyc = 0;
  int mdl_d = 0;
  bit mdl_armed = 1'b0;

  always @(posedge clk) begin
    if (mdl_armed && start_i) mdl_cyc <= 1;
    else if (mdl_cyc != 0) mdl_cyc <= (mdl_cyc > run_len(mdl_d)) ? 0 : mdl_cyc + 1;
  end

  always @(negedge clk) begin
    int   n, p, o;
    logic exp_l;
    if (mdl_cyc != 0 && rst_n) begin
      n = run_len(mdl_d);
      p = trial_period(mdl_d);
      if (mdl_cyc <= n) begin
        o = (mdl_cyc - 1) % p;
        exp_l = (mdl_cyc < n) && (o >= SETTLE) && (o < SETTLE + trial_count(mdl_d) + 1);
        check("cyc_busy_done_launch", {busy_o, done_o, launch_o}, {1'b1, 1'b0, exp_l});
      end else begin
        check("cyc_done_flags", {busy_o, done_o, launch_o}, 3'b010);
        check("cyc_sum", sum_o, 4 * trial_count(mdl_d));
        check("cyc_avg", avg_o, trial_count(mdl_d));
        check("cyc_err", err_o, 0);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
  endtask

  // called at the negedge of the first busy cycle; lat counts that cycle as 1
  task automatic wait_done(input int bound, output int lat, output int rises);
    logic prev;
    prev = launch_o;
    lat = 1;
    rises = 0;
    while (!done_o && lat < bound) begin
      @(negedge clk);
      lat++;
      if (launch_o && !prev) rises++;
      prev = launch_o;
    end
  endtask

  task automatic run_loop(input int d, input int exp_sum, input int exp_avg, input int exp_lat);
    int lat, rises;
    dly = d;
    tie1 = 1'b0;
    repeat (4) @(negedge clk);
    mdl_d = d;
    mdl_armed = 1'b1;
    pulse_start();
    mdl_armed = 1'b0;
    wait_done(400, lat, rises);
    $display("[TB] run delay=%0d latency=%0d rises=%0d sum=%0d avg=%0d err=%0d",
             d, lat, rises, sum_o, avg_o, err_o);
    check("run_latency", lat, exp_lat);
    check("run_launch_rises", rises, 4);
    check("run_sum", sum_o, exp_sum);
    check("run_avg", avg_o, exp_avg);
    check("run_err", err_o, 2'b00);
    @(negedge clk);
    check("run_done_single", done_o, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, rises, cyc, first_rise, second_rise, done_seen;
    logic prev;

    repeat (2) @(negedge clk);
    check("rst_outputs", {launch_o, busy_o, done_o, err_o, sum_o, avg_o}, 0);
    check("rst_outputs_to", {launch2, busy2, done2, err2, sum2, avg2}, 0);
    rst_n = 1'b1;
    $display("[TB] reset released");

    // zero-delay loopback: 4 trials of 2 cycles each
    run_loop(0, 8, 2, 90);

    // sense stuck high: settle never completes, partial (empty) sum reported
    tie1 = 1'b1;
    repeat (5) @(negedge clk);
    pulse_start();
    wait_done(1100, lat, rises);
    $display("[TB] stuck-high latency=%0d rises=%0d err=%0d sum=%0d", lat, rises, err_o, sum_o);
    check("stuck1_latency", lat, 1002);
    check("stuck1_no_launch", rises, 0);
    check("stuck1_err", err_o, 2'b10);
    check("stuck1_sum", sum_o, 0);
    check("stuck1_avg", avg_o, 0);
    @(negedge clk);
    check("stuck1_done_single", done_o, 1'b0);
    tie1 = 1'b0;

    // five-cycle chain: 4 trials of 7 cycles each
    run_loop(5, 28, 7, 130);

    // re-pulsed start ignored; abort in trial 2 measure
    dly = 0;
    repeat (4) @(negedge clk);
    pulse_start();
    cyc = 1; first_rise = 0; second_rise = 0; prev = launch_o;
    while (second_rise == 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 10) start_i = 1'b1;
      if (cyc == 11) start_i = 1'b0;
      if (launch_o && !prev) begin
        if (first_rise == 0) first_rise = cyc;
        else second_rise = cyc;
      end
      prev = launch_o;
    end
    $display("[TB] abort run first_rise=%0d second_rise=%0d", first_rise, second_rise);
    check("restart_ignored_rise1", first_rise, 17);
    check("restart_ignored_rise2", second_rise, 39);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("abort_idle", {busy_o, launch_o, done_o}, 3'b000);
    done_seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (done_o) done_seen++;
    end
    $display("[TB] after abort done_seen=%0d sum=%0d avg=%0d err=%0d", done_seen, sum_o, avg_o, err_o);
    check("abort_no_done", done_seen, 0);
    check("abort_sum_kept", sum_o, 28);
    check("abort_avg_kept", avg_o, 7);
    check("abort_err_kept", err_o, 2'b00);

    // short-timeout instance with sense tied low: rise timeout
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    lat = 1; rises = 0; prev = launch2;
    while (!done2 && lat < 200) begin
      @(negedge clk);
      lat++;
      if (launch2 && !prev) rises++;
      prev = launch2;
    end
    $display("[TB] rise-timeout latency=%0d rises=%0d err=%0d sum=%0d", lat, rises, err2, sum2);
    check("rto_latency", lat, 68);
    check("rto_err", err2, 2'b01);
    check("rto_sum", sum2, 0);
    check("rto_launch_low", launch2, 1'b0);
    check("rto_one_launch", rises, 1);
    @(negedge clk);
    check("rto_done_single", done2, 1'b0);

    // asynchronous reset in the middle of a measure phase
    dly = 0;
    repeat (4) @(negedge clk);
    pulse_start();
    cyc = 1;
    while (!launch_o && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("reset_run_reached_measure", launch_o, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    $display("[TB] async reset launch=%0d busy=%0d sum=%0d err=%0d", launch_o, busy_o, sum_o, err_o);
    check("areset_outputs", {launch_o, busy_o, done_o, err_o, sum_o, avg_o}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_loop(0, 8, 2, 90);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
